// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller for the team FIFO: pops words into a small circular
// buffer and presents them downstream on a registered valid/ready stream.
module fifo_drain_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LAT     = 0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  words_sent
);

    localparam int unsigned BUF_DEPTH = 2 + RD_LAT;
    localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
    localparam bit          HAS_LAT   = (RD_LAT != 32'd0);

    if (RD_LAT > 32'd1) begin : g_bad_rd_lat
        $error("fifo_drain_ctrl: RD_LAT must be 0 or 1");
    end

    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [2:0]            occ_q;
    logic                  inflight_q;
    logic [2:0]            fill;
    logic                  capture;
    logic                  xfer;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Reserve a slot for every word already requested so a late capture always fits.
    assign fill     = occ_q + {2'b00, inflight_q};
    assign fifo_pop = reset && enable && !fifo_empty && (fill < 3'(BUF_DEPTH));

    if (RD_LAT == 32'd0) begin : g_lat0
        assign capture = fifo_pop;
    end else begin : g_lat1
        assign capture = inflight_q;
    end

    assign out_valid = (occ_q != 3'd0);
    assign out_data  = buf_q[head_q];
    assign xfer      = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            words_sent <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            // A pop and a capture in the same cycle leave one word still in flight.
            inflight_q <= HAS_LAT && fifo_pop;
            if (capture) begin
                buf_q[tail_q] <= fifo_data;
                tail_q        <= ptr_inc(tail_q);
            end
            if (xfer) begin
                head_q     <= ptr_inc(head_q);
                words_sent <= words_sent + CNT_WIDTH'(1);
            end
            if (capture && !xfer) begin
                occ_q <= occ_q + 3'd1;
            end else if (!capture && xfer) begin
                occ_q <= occ_q - 3'd1;
            end
        end
    end

endmodule

// File: doc/fifo_drain_ctrl.md
Name: fifo_drain_ctrl

Overview:
Read-side controller for the team FIFO.
- Pops words from the FIFO whenever it has room and presents them downstream on a registered valid/ready stream.
- Holds a small internal output buffer, so FIFO read latency and downstream back-pressure never lose or duplicate a word.
- Sits between the FIFO's DataOutput/empty/pop side and any consumer: serializer, bus master, etc.

Parameters:
DATA_WIDTH, 8, width of FIFO words and out_data
RD_LAT, 0, FIFO read latency in clk cycles. 0 = show-ahead: data valid with !empty, consumed at the pop edge. 1 = data valid the cycle after pop. Only 0 and 1 are legal.
CNT_WIDTH, 16, width of the delivered-word counter

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
enable  input  1  1 = allowed to issue new pops
fifo_data  input  DATA_WIDTH  FIFO DataOutput
fifo_empty  input  1  FIFO empty flag
fifo_pop  output  1  pop strobe to FIFO, one word per high cycle
out_data  output  DATA_WIDTH  head word of the output buffer
out_valid  output  1  out_data holds a valid word
out_ready  input  1  consumer accepts out_data this cycle
words_sent  output  CNT_WIDTH  count of completed out_valid&&out_ready transfers; wraps modulo 2^CNT_WIDTH

Behaviour:
- Buffer: circular, BUF_DEPTH = 2+RD_LAT entries, with head/tail pointers and occupancy occ (0..BUF_DEPTH).
- In-flight counter inflight (0..RD_LAT): pops issued whose data has not yet arrived. For RD_LAT=0 it is always 0.
- fifo_pop = reset && enable && !fifo_empty && (occ+inflight < BUF_DEPTH). It is combinational from registered state plus fifo_empty/enable; it must not depend on out_ready.
- Capture, RD_LAT=0: fifo_data is written to the tail on the same edge fifo_pop is high.
- Capture, RD_LAT=1: fifo_data is written on the edge after a pop. inflight is set on pop and cleared on capture; a pop and a capture in the same cycle keep it at 1.
- out_valid = (occ != 0); out_data = buffer[head]. Both come from registers only, with no combinational path from fifo_data.
- Transfer = out_valid && out_ready: head advances, occ decrements, words_sent increments.
- Capture and transfer in the same cycle: occ unchanged, both pointers advance.
- Ordering: strict FIFO order. No word is dropped, duplicated or reordered under any out_ready pattern.
- Throughput: with FIFO non-empty, enable=1 and out_ready held 1, one transfer every cycle in steady state, for both RD_LAT values.
- Latency to first out_valid, from the first pop edge into an empty buffer: RD_LAT=0 gives 1 cycle; RD_LAT=1 gives 2 cycles.
- enable deasserted: no new pops. In-flight data is still captured, and buffered words are still delivered.
- out_ready ignored when out_valid=0: no count change.
- Reset (reset=0), asynchronous, any time including mid-transfer: occ=0, inflight=0, pointers=0, out_valid=0, out_data=0, words_sent=0, fifo_pop=0. Buffered and in-flight words are discarded.
- Illegal RD_LAT values are a parameter error; the implementation guards this with a generate-time check.

Test Plan:
1. RD_LAT=0, FIFO holds 0x11,0x22,0x33, enable=1, out_ready=1 -> out_valid rises 1 cycle after first pop; 0x11,0x22,0x33 on consecutive cycles; words_sent=3; fifo_pop low once fifo_empty=1.
2. RD_LAT=0, FIFO holds 5 words, out_ready=0 -> exactly 2 pops then fifo_pop stays 0. Then out_ready=1 -> all 5 words delivered in order, 1 per cycle.
3. RD_LAT=1, 8 words 0x00..0x07, out_ready=1 -> first out_valid 2 cycles after first pop, then 8 back-to-back transfers; never more than 3 words buffered plus in flight.
4. Random out_ready (~50%) with 64 incrementing words, both RD_LAT values -> output sequence identical to input and words_sent=64. Also preload words_sent near 2^CNT_WIDTH-1 (force) -> wraps to 0.
5. enable dropped after 2 pops with RD_LAT=1 -> in-flight word still appears; no further pops until enable=1.
6. reset pulsed low asynchronously while occ=2 -> out_valid, out_data, words_sent and fifo_pop go 0 immediately. After release, the next FIFO word is delivered correctly.
